maze_grid_renderer: RTL

Parametrised maze-map store and pixel colouriser that sits between the radio packet receiver and `VGA_DRIVER`. It accepts cell-update packets over a valid/ready handshake and keeps a GRID_W × GRID_H array of 3-bit cell codes. It maps each incoming pixel coordinate to a tile colour through a 2-stage pipeline. Only one "current" cell may exist at a time; when a new current cell is written, the previous one is automatically demoted to "visited".

---
 rtl/maze_grid_renderer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/maze_grid_renderer.sv
// maze_grid_renderer
//
// Maze-map store and pixel colouriser between the radio packet receiver and
// VGA_DRIVER. It holds a GRID_W x GRID_H array of 3-bit cell codes, which are
// updated by packets over a valid/ready handshake. It maps each pixel
// coordinate to a tile colour through a 2-stage pipeline. Only one "current"
// cell (code 6) exists at a time. Moving it demotes the old one to "visited".
//
// State table (update FSM):
//   state      | meaning
//   ST_IDLE    | ready for a packet; single-cycle writes and rejects happen here
//   ST_DEMOTE  | writing code 1 over the previous current cell
//   ST_COMMIT  | writing code 6 to the latched cell and moving the pointer
//
// Ports:
//   CLOCK        pixel clock (25 MHz), single domain
//   RESET        asynchronous, active-high
//   UPD_VALID    update packet present
//   UPD_READY    packet accepted on this edge when UPD_VALID is also high
//   UPD_X/Y      target cell column / row
//   UPD_CODE     cell code (7 is reserved and rejected)
//   PIXEL_X/Y    pixel coordinate from VGA_DRIVER
//   PIXEL_COLOR  RRRGGGBB, 2 cycles after its coordinate
//   FRAME_DONE   one-cycle pulse aligned with the colour of the last grid pixel
//   DROP_COUNT   saturating count of rejected packets
`timescale 1ns/1ps

module maze_grid_renderer #(
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 5,
  parameter int X_BITS     = 2,
  parameter int Y_BITS     = 3,
  parameter int TILE_LOG2  = 6,
  parameter int GRID_LINES = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              UPD_VALID,
  output logic              UPD_READY,
  input  logic [X_BITS-1:0] UPD_X,
  input  logic [Y_BITS-1:0] UPD_Y,
  input  logic [2:0]        UPD_CODE,
  input  logic [9:0]        PIXEL_X,
  input  logic [9:0]        PIXEL_Y,
  output logic [7:0]        PIXEL_COLOR,
  output logic              FRAME_DONE,
  output logic [7:0]        DROP_COUNT
);

  localparam int N_CELLS = GRID_W * GRID_H;
  localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  // One extra bit so a grid dimension of exactly 2^BITS still compares correctly.
  localparam logic [X_BITS:0] GRID_W_X = (X_BITS+1)'(GRID_W);
  localparam logic [Y_BITS:0] GRID_H_Y = (Y_BITS+1)'(GRID_H);

  localparam logic [9:0] GRID_W_T   = 10'(GRID_W);
  localparam logic [9:0] GRID_H_T   = 10'(GRID_H);
  localparam logic [9:0] LOCAL_MASK = 10'((1 << TILE_LOG2) - 1);
  localparam logic [9:0] LAST_X     = 10'(GRID_W * (1 << TILE_LOG2) - 1);
  localparam logic [9:0] LAST_Y     = 10'(GRID_H * (1 << TILE_LOG2) - 1);

  localparam logic [2:0] CODE_VISITED  = 3'd1;
  localparam logic [2:0] CODE_CURRENT  = 3'd6;
  localparam logic [2:0] CODE_RESERVED = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEMOTE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       cells [N_CELLS];
  logic             ptr_valid;
  logic [IDX_W-1:0] ptr_idx;
  logic [IDX_W-1:0] latch_idx;
  logic [7:0]       drop_cnt;
  logic             upd_ready_q;

  logic             pkt_accept;
  logic             pkt_bad;
  logic [IDX_W-1:0] pkt_idx;

  assign UPD_READY  = upd_ready_q;
  assign DROP_COUNT = drop_cnt;

  assign pkt_accept = UPD_VALID & upd_ready_q;
  assign pkt_bad    = ({1'b0, UPD_X} >= GRID_W_X) |
                      ({1'b0, UPD_Y} >= GRID_H_Y) |
                      (UPD_CODE == CODE_RESERVED);
  // Only meaningful for in-range packets; rejected packets never use it.
  assign pkt_idx    = IDX_W'(UPD_Y) * IDX_W'(GRID_W) + IDX_W'(UPD_X);

  // ---------------------------------------------------------------------------
  // Update FSM and grid storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      upd_ready_q <= 1'b1;
      ptr_valid   <= 1'b0;
      ptr_idx     <= '0;
      latch_idx   <= '0;
      drop_cnt    <= 8'd0;
      for (int i = 0; i < N_CELLS; i++) begin
        cells[i] <= 3'd0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (pkt_accept) begin
            if (pkt_bad) begin
              if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
              end
            end else if (UPD_CODE != CODE_CURRENT) begin
              cells[pkt_idx] <= UPD_CODE;
              // Overwriting the current cell leaves no current cell behind.
              if (ptr_valid && (ptr_idx == pkt_idx)) begin
                ptr_valid <= 1'b0;
              end
            end else if (ptr_valid && (ptr_idx != pkt_idx)) begin
              latch_idx   <= pkt_idx;
              state       <= ST_DEMOTE;
              upd_ready_q <= 1'b0;
            end else begin
              cells[pkt_idx] <= CODE_CURRENT;
              ptr_idx        <= pkt_idx;
              ptr_valid      <= 1'b1;
            end
          end
        end
        ST_DEMOTE: begin
          cells[ptr_idx] <= CODE_VISITED;
          state          <= ST_COMMIT;
        end
        ST_COMMIT: begin
          cells[latch_idx] <= CODE_CURRENT;
          ptr_idx          <= latch_idx;
          ptr_valid        <= 1'b1;
          state            <= ST_IDLE;
          upd_ready_q      <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          upd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Render pipeline
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] code_color(input logic [2:0] code);
    logic [7:0] c;
    case (code)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hFC;
      3'd2:    c = 8'h3F;
      3'd3:    c = 8'hE0;
      3'd4:    c = 8'h1C;
      3'd5:    c = 8'h03;
      3'd6:    c = 8'hEC;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [9:0]       tile_col;
  logic [9:0]       tile_row;
  logic             in_grid;
  logic             on_line;
  logic             at_last;
  logic [IDX_W-1:0] pix_idx;

  assign tile_col = PIXEL_X >> TILE_LOG2;
  assign tile_row = PIXEL_Y >> TILE_LOG2;
  assign in_grid  = (tile_col < GRID_W_T) && (tile_row < GRID_H_T);
  assign on_line  = (GRID_LINES != 0) &&
                    (((PIXEL_X & LOCAL_MASK) == 10'd0) || ((PIXEL_Y & LOCAL_MASK) == 10'd0));
  assign at_last  = (PIXEL_X == LAST_X) && (PIXEL_Y == LAST_Y);
  assign pix_idx  = IDX_W'(tile_row) * IDX_W'(GRID_W) + IDX_W'(tile_col);

  logic             s1_in_grid;
  logic             s1_line;
  logic             s1_frame;
  logic [IDX_W-1:0] s1_idx;
  logic             prev_at_last;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1_in_grid   <= 1'b0;
      s1_line      <= 1'b0;
      s1_frame     <= 1'b0;
      s1_idx       <= '0;
      prev_at_last <= 1'b0;
      PIXEL_COLOR  <= 8'h00;
      FRAME_DONE   <= 1'b0;
    end else begin
      s1_in_grid   <= in_grid;
      s1_line      <= on_line;
      // Out-of-grid tiles park at index 0 so the lookup never leaves the array.
      s1_idx       <= in_grid ? pix_idx : '0;
      // Only the first cycle on the last pixel counts, so a stalled driver
      // holding the coordinate still yields a single pulse.
      s1_frame     <= at_last & ~prev_at_last;
      prev_at_last <= at_last;

      // Cell read happens here, so a write on this same edge renders old data.
      if (!s1_in_grid) begin
        PIXEL_COLOR <= 8'h00;
      end else if (s1_line) begin
        PIXEL_COLOR <= 8'h49;
      end else begin
        PIXEL_COLOR <= code_color(cells[s1_idx]);
      end
      FRAME_DONE <= s1_frame;
    end
  end

endmodule
